// File: rtl/atm_pkg.sv
// Shared types and helpers for the ATM transaction controller.
package atm_pkg;

    // Controller states; exported on the top-level debug port.
    typedef enum logic [2:0] {
        IDLE,
        PIN_ENTRY,
        PIN_CHECK,
        MONTO_WAIT,
        TRANSACTION,
        LOCKED
    } atm_state_e;

    // Outcome of a latched transaction, decided from balance, limit and type.
    typedef logic [2:0] res_code_t;
    localparam res_code_t RES_NINGUNO  = 3'd0;
    localparam res_code_t RES_DEPOSITO = 3'd1;
    localparam res_code_t RES_RETIRO   = 3'd2;
    localparam res_code_t RES_FONDOS   = 3'd3;
    localparam res_code_t RES_LIMITE   = 3'd4;

    // Width able to hold the attempt count 0..max_intentos.
    function automatic int unsigned intentos_w(input int unsigned max_intentos);
        return $clog2(max_intentos + 1);
    endfunction

endpackage

// File: rtl/atm_strobe_edge.sv
// Registers an asynchronous-ish level strobe and flags its rising edge.
//
// Strobe handshake: the front end raises the strobe with its data already
// stable and keeps the data stable until the strobe has been low for at
// least one full cycle.  The strobe is sampled once per clock; edge_pulse is
// high for exactly one cycle after the first high sample, however long the
// strobe stays high.  There is no ready/backpressure: an edge arriving while
// the owner is not listening is simply dropped by the owner.
module atm_strobe_edge (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    output logic edge_pulse
);

    logic stb_q;
    logic stb_qq;

    // Two-stage sample of the strobe; the older copy gives the edge reference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_q  <= 1'b0;
            stb_qq <= 1'b0;
        end else begin
            stb_q  <= stb;
            stb_qq <= stb_q;
        end
    end

    assign edge_pulse = stb_q & ~stb_qq;

endmodule

// File: rtl/atm_controller_param.sv
// ATM transaction controller: card/PIN session, attempt lockout, deposits,
// withdrawals with a daily limit, inactivity timeout and session cancel.
module atm_controller_param
    import atm_pkg::*;
#(
    parameter int unsigned     PIN_DIGITS    = 4,
    parameter int unsigned     MAX_INTENTOS  = 3,
    parameter int unsigned     MONTO_W       = 32,
    parameter int unsigned     BAL_W         = 64,
    parameter longint unsigned BALANCE_INI   = 400000,
    parameter longint unsigned LIMITE_DIARIO = 200000,
    parameter int unsigned     TIMEOUT_CYC   = 1000
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    TARJETA_RECIBIDA,
    input  logic                    TIPO_TRANS,
    input  logic                    DIGITO_STB,
    input  logic [3:0]              DIGITO,
    input  logic [4*PIN_DIGITS-1:0] PIN,
    input  logic                    MONTO_STB,
    input  logic [MONTO_W-1:0]      MONTO,
    input  logic                    CANCELAR,
    input  logic                    DIA_NUEVO,
    output logic [BAL_W-1:0]        BALANCE,
    output logic                    BALANCE_ACTUALIZADO,
    output logic                    ENTREGAR_DINERO,
    output logic                    PIN_INCORRECTO,
    output logic                    ADVERTENCIA,
    output logic                    BLOQUEO,
    output logic                    FONDOS_INSUFICIENTES,
    output logic                    LIMITE_EXCEDIDO,
    output logic                    TIEMPO_AGOTADO,
    output atm_state_e              state_dbg
);

    localparam int unsigned PIN_W  = 4 * PIN_DIGITS;
    localparam int unsigned DCNT_W = $clog2(PIN_DIGITS + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned INT_W  = intentos_w(MAX_INTENTOS);

    localparam logic [DCNT_W-1:0] DIG_LAST   = DCNT_W'(PIN_DIGITS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [INT_W-1:0]  INT_LOCK   = INT_W'(MAX_INTENTOS);
    localparam logic [INT_W-1:0]  INT_WARN   = INT_W'(MAX_INTENTOS - 1);
    localparam logic [BAL_W:0]    LIMITE_EXT = (BAL_W + 1)'(LIMITE_DIARIO);
    localparam logic [BAL_W-1:0]  BAL_RESET  = BAL_W'(BALANCE_INI);
    localparam logic [BAL_W-1:0]  BAL_MAX    = '1;

    atm_state_e        state;
    logic [INT_W-1:0]  intentos;
    logic [INT_W-1:0]  intentos_inc;
    logic [DCNT_W-1:0] dig_cnt;
    logic [PIN_W-1:0]  pin_sr;
    logic [TMR_W-1:0]  timer;
    logic [BAL_W-1:0]  acum;
    logic [BAL_W-1:0]  monto_q;
    logic              tipo_q;
    logic              dig_edge;
    logic              monto_edge;
    logic [BAL_W:0]    dep_sum;
    logic [BAL_W:0]    acum_sum;
    res_code_t         res_code;

    atm_strobe_edge u_dig_edge (
        .clk        (CLK),
        .rst        (RESET),
        .stb        (DIGITO_STB),
        .edge_pulse (dig_edge)
    );

    atm_strobe_edge u_monto_edge (
        .clk        (CLK),
        .rst        (RESET),
        .stb        (MONTO_STB),
        .edge_pulse (monto_edge)
    );

    // Sums carry one extra bit so saturation and the limit test never wrap.
    assign intentos_inc = intentos + 1'b1;
    assign dep_sum      = {1'b0, BALANCE} + {1'b0, monto_q};
    assign acum_sum     = {1'b0, acum} + {1'b0, monto_q};
    assign state_dbg    = state;

    // Classify the latched transaction; funds are checked before the limit.
    always_comb begin
        res_code = RES_NINGUNO;
        if (!tipo_q)
            res_code = RES_DEPOSITO;
        else if (monto_q > BALANCE)
            res_code = RES_FONDOS;
        else if (acum_sum > LIMITE_EXT)
            res_code = RES_LIMITE;
        else
            res_code = RES_RETIRO;
    end

    // Session FSM with timer, PIN shifter, attempt counter and balance datapath.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state                <= IDLE;
            BALANCE              <= BAL_RESET;
            intentos             <= '0;
            dig_cnt              <= '0;
            pin_sr               <= '0;
            timer                <= '0;
            acum                 <= '0;
            monto_q              <= '0;
            tipo_q               <= 1'b0;
            BALANCE_ACTUALIZADO  <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            PIN_INCORRECTO       <= 1'b0;
            ADVERTENCIA          <= 1'b0;
            BLOQUEO              <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            LIMITE_EXCEDIDO      <= 1'b0;
            TIEMPO_AGOTADO       <= 1'b0;
        end else begin
            BALANCE_ACTUALIZADO  <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            PIN_INCORRECTO       <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            LIMITE_EXCEDIDO      <= 1'b0;
            TIEMPO_AGOTADO       <= 1'b0;
            case (state)
                IDLE: begin
                    if (TARJETA_RECIBIDA) begin
                        state   <= PIN_ENTRY;
                        dig_cnt <= '0;
                        pin_sr  <= '0;
                        timer   <= '0;
                    end
                end
                PIN_ENTRY: begin
                    if (CANCELAR) begin
                        state <= IDLE;
                    end else if (timer == TMR_LAST) begin
                        // Partial PIN is dropped; it does not count as an attempt.
                        TIEMPO_AGOTADO <= 1'b1;
                        state          <= IDLE;
                    end else if (dig_edge) begin
                        pin_sr  <= (pin_sr << 4) | PIN_W'(DIGITO);
                        dig_cnt <= dig_cnt + 1'b1;
                        timer   <= '0;
                        if (dig_cnt == DIG_LAST)
                            state <= PIN_CHECK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PIN_CHECK: begin
                    if (CANCELAR) begin
                        state <= IDLE;
                    end else if (pin_sr == PIN) begin
                        intentos    <= '0;
                        ADVERTENCIA <= 1'b0;
                        timer       <= '0;
                        state       <= MONTO_WAIT;
                    end else begin
                        PIN_INCORRECTO <= 1'b1;
                        intentos       <= intentos_inc;
                        if (intentos_inc == INT_LOCK) begin
                            BLOQUEO     <= 1'b1;
                            ADVERTENCIA <= 1'b0;
                            state       <= LOCKED;
                        end else begin
                            if (intentos_inc == INT_WARN)
                                ADVERTENCIA <= 1'b1;
                            dig_cnt <= '0;
                            timer   <= '0;
                            state   <= PIN_ENTRY;
                        end
                    end
                end
                MONTO_WAIT: begin
                    if (CANCELAR) begin
                        state <= IDLE;
                    end else if (timer == TMR_LAST) begin
                        TIEMPO_AGOTADO <= 1'b1;
                        state          <= IDLE;
                    end else if (monto_edge) begin
                        monto_q <= BAL_W'(MONTO);
                        tipo_q  <= TIPO_TRANS;
                        state   <= TRANSACTION;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                TRANSACTION: begin
                    // CANCELAR is deliberately not looked at: the transaction completes.
                    case (res_code)
                        RES_DEPOSITO: begin
                            BALANCE             <= dep_sum[BAL_W] ? BAL_MAX : dep_sum[BAL_W-1:0];
                            BALANCE_ACTUALIZADO <= 1'b1;
                        end
                        RES_RETIRO: begin
                            BALANCE             <= BALANCE - monto_q;
                            acum                <= acum_sum[BAL_W-1:0];
                            ENTREGAR_DINERO     <= 1'b1;
                            BALANCE_ACTUALIZADO <= 1'b1;
                        end
                        RES_FONDOS: FONDOS_INSUFICIENTES <= 1'b1;
                        RES_LIMITE: LIMITE_EXCEDIDO      <= 1'b1;
                        default: ;
                    endcase
                    state <= IDLE;
                end
                LOCKED: state <= LOCKED;
                default: state <= IDLE;
            endcase
            // A new day wins over a withdrawal landing in the same cycle.
            if (DIA_NUEVO)
                acum <= '0;
        end
    end

endmodule

// File: tb/tb_atm_controller_param.sv
// Self-checking bench for atm_controller_param: directed scenarios followed by
// randomized sessions scored against a behavioural account model.
module tb_atm_controller_param;
    import atm_pkg::*;

    localparam int              PIN_W       = 16;
    localparam int              MAX_INT     = 3;
    localparam int              TMO         = 20;
    localparam longint unsigned BAL_INI     = 400000;
    localparam longint unsigned LIMITE      = 200000;
    localparam longint unsigned BAL_MAX     = 64'hFFFF_FFFF_FFFF_FFFF;

    // ---------------- clock / reset / DUT ----------------
    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             TARJETA_RECIBIDA = 1'b0;
    logic             TIPO_TRANS = 1'b0;
    logic             DIGITO_STB = 1'b0;
    logic [3:0]       DIGITO = 4'd0;
    logic [PIN_W-1:0] PIN = 16'h9547;
    logic             MONTO_STB = 1'b0;
    logic [31:0]      MONTO = 32'd0;
    logic             CANCELAR = 1'b0;
    logic             DIA_NUEVO = 1'b0;
    logic [63:0]      BALANCE;
    logic             BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO;
    logic             ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES, LIMITE_EXCEDIDO, TIEMPO_AGOTADO;
    atm_state_e       state_dbg;

    always #5 CLK = ~CLK;

    atm_controller_param #(.TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA),
        .TIPO_TRANS(TIPO_TRANS), .DIGITO_STB(DIGITO_STB), .DIGITO(DIGITO),
        .PIN(PIN), .MONTO_STB(MONTO_STB), .MONTO(MONTO), .CANCELAR(CANCELAR),
        .DIA_NUEVO(DIA_NUEVO), .BALANCE(BALANCE),
        .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO), .ENTREGAR_DINERO(ENTREGAR_DINERO),
        .PIN_INCORRECTO(PIN_INCORRECTO), .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO),
        .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES), .LIMITE_EXCEDIDO(LIMITE_EXCEDIDO),
        .TIEMPO_AGOTADO(TIEMPO_AGOTADO), .state_dbg(state_dbg)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];          // expected BALANCE at each BALANCE_ACTUALIZADO pulse
    longint unsigned m_bal  = BAL_INI;
    longint unsigned m_acum = 0;
    int m_att = 0;
    bit m_locked = 1'b0;
    int e_ent = 0, e_act = 0, e_inc = 0, e_fon = 0, e_lim = 0, e_tmo = 0;
    int cnt_ent = 0, cnt_act = 0, cnt_inc = 0, cnt_fon = 0, cnt_lim = 0, cnt_tmo = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts each cycle a pulse is high and scores balance updates.
    always @(negedge CLK) begin
        if (!RESET) begin
            cnt_ent += int'(ENTREGAR_DINERO);
            cnt_act += int'(BALANCE_ACTUALIZADO);
            cnt_inc += int'(PIN_INCORRECTO);
            cnt_fon += int'(FONDOS_INSUFICIENTES);
            cnt_lim += int'(LIMITE_EXCEDIDO);
            cnt_tmo += int'(TIEMPO_AGOTADO);
            if (BALANCE_ACTUALIZADO) begin
                if (exp_q.size() == 0)
                    check_eq("upd_unexpected", 64'(BALANCE_ACTUALIZADO), 64'd0);
                else
                    check_eq("upd_balance", BALANCE, exp_q.pop_front());
            end
        end
    end

    function automatic logic [PIN_W-1:0] rand_pin();
        logic [PIN_W-1:0] p;
        for (int i = 0; i < 4; i++) p[4*i +: 4] = 4'($urandom_range(0, 9));
        return p;
    endfunction

    function automatic logic [PIN_W-1:0] wrong_pin(input logic [PIN_W-1:0] good);
        logic [PIN_W-1:0] p;
        p = rand_pin();
        if (p == good) p[3:0] = (good[3:0] == 4'd0) ? 4'd1 : 4'd0;
        return p;
    endfunction

    function automatic logic [31:0] rand_amount();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'd0;
        if (r <= 6) return 32'($urandom_range(1, 120000));
        if (r <= 8) return 32'($urandom_range(100000, 500000));
        return 32'($urandom);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        m_bal = BAL_INI; m_acum = 0; m_att = 0; m_locked = 1'b0;
        exp_q.delete();
        @(negedge CLK);
    endtask

    task automatic insert_card();
        TARJETA_RECIBIDA = 1'b1;
        @(negedge CLK);
        TARJETA_RECIBIDA = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d, input int hold);
        DIGITO = d;
        DIGITO_STB = 1'b1;
        repeat (hold) @(negedge CLK);
        DIGITO_STB = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    // hold = 0 picks a random strobe width per digit.
    task automatic enter_pin(input logic [PIN_W-1:0] p, input int hold);
        for (int d = 3; d >= 0; d--)
            send_digit(p[4*d +: 4], (hold == 0) ? int'($urandom_range(1, 3)) : hold);
        if (!m_locked) begin
            if (p == PIN) m_att = 0;
            else begin
                m_att++;
                e_inc++;
                if (m_att == MAX_INT) m_locked = 1'b1;
            end
        end
        @(negedge CLK);
    endtask

    task automatic send_amount(input bit tipo, input logic [31:0] m);
        longint unsigned mm;
        mm = 64'(m);
        if (!m_locked) begin
            if (!tipo) begin
                m_bal = (m_bal > BAL_MAX - mm) ? BAL_MAX : m_bal + mm;
                e_act++;
                exp_q.push_back(m_bal);
            end else if (mm > m_bal) e_fon++;
            else if (m_acum + mm > LIMITE) e_lim++;
            else begin
                m_bal -= mm;
                m_acum += mm;
                e_ent++;
                e_act++;
                exp_q.push_back(m_bal);
            end
        end
        TIPO_TRANS = tipo;
        MONTO = m;
        MONTO_STB = 1'b1;
        repeat (2) @(negedge CLK);
        MONTO_STB = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic pulse_dia();
        DIA_NUEVO = 1'b1;
        @(negedge CLK);
        DIA_NUEVO = 1'b0;
        m_acum = 0;
    endtask

    task automatic cancel_now();
        CANCELAR = 1'b1;
        @(negedge CLK);
        CANCELAR = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic check_state();
        @(negedge CLK);
        check_eq("balance", BALANCE, m_bal);
        check_eq("advertencia", 64'(ADVERTENCIA), 64'(m_att == MAX_INT - 1 && !m_locked));
        check_eq("bloqueo", 64'(BLOQUEO), 64'(m_locked));
        check_eq("state", 64'(state_dbg), 64'(m_locked ? LOCKED : IDLE));
        check_eq("n_entregar", 64'(cnt_ent), 64'(e_ent));
        check_eq("n_actualizado", 64'(cnt_act), 64'(e_act));
        check_eq("n_pin_incorrecto", 64'(cnt_inc), 64'(e_inc));
        check_eq("n_fondos", 64'(cnt_fon), 64'(e_fon));
        check_eq("n_limite", 64'(cnt_lim), 64'(e_lim));
        check_eq("n_timeout", 64'(cnt_tmo), 64'(e_tmo));
    endtask

    task automatic run_session(input int nw, input bit cancel, input bit tipo,
                               input logic [31:0] m, input int hold);
        insert_card();
        for (int i = 0; i < nw; i++) enter_pin(wrong_pin(PIN), hold);
        enter_pin(PIN, hold);
        if (cancel) cancel_now();
        else send_amount(tipo, m);
        repeat (2) @(negedge CLK);
        check_state();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        @(negedge CLK);
        check_eq("rst_balance", BALANCE, 64'd400000);
        check_eq("rst_state", 64'(state_dbg), 64'(IDLE));
        check_eq("rst_pulses", 64'({BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO,
                 FONDOS_INSUFICIENTES, LIMITE_EXCEDIDO, TIEMPO_AGOTADO}), 64'd0);
        check_eq("rst_levels", 64'({ADVERTENCIA, BLOQUEO}), 64'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Withdrawal with every digit strobe held for three cycles.
        run_session(0, 1'b0, 1'b1, 32'd50000, 3);
        check_eq("wd_balance", BALANCE, 64'd350000);
        check_eq("wd_entregar", 64'(cnt_ent), 64'd1);

        // Deposit from reset.
        do_reset();
        run_session(0, 1'b0, 1'b0, 32'd50000, 0);
        check_eq("dep_balance", BALANCE, 64'd450000);
        check_eq("dep_entregar", 64'(cnt_ent), 64'd1);

        // Insufficient funds, daily limit, new day.
        do_reset();
        run_session(0, 1'b0, 1'b1, 32'd410000, 0);
        check_eq("fondos_balance", BALANCE, 64'd400000);
        run_session(0, 1'b0, 1'b1, 32'd150000, 0);
        run_session(0, 1'b0, 1'b1, 32'd60000, 0);
        check_eq("limite_balance", BALANCE, 64'd250000);
        pulse_dia();
        run_session(0, 1'b0, 1'b1, 32'd60000, 0);
        check_eq("dia_nuevo_balance", BALANCE, 64'd190000);

        // Lockout after three wrong PINs.
        do_reset();
        insert_card();
        enter_pin(16'h9147, 0);
        check_eq("lock1_adv", 64'(ADVERTENCIA), 64'd0);
        enter_pin(16'h9177, 0);
        check_eq("lock2_adv", 64'(ADVERTENCIA), 64'd1);
        enter_pin(16'h9143, 0);
        check_eq("lock3_bloqueo", 64'(BLOQUEO), 64'd1);
        check_eq("lock3_adv", 64'(ADVERTENCIA), 64'd0);
        insert_card();
        enter_pin(PIN, 0);
        send_amount(1'b1, 32'd1000);
        check_state();
        do_reset();
        check_eq("unlock_bloqueo", 64'(BLOQUEO), 64'd0);
        check_eq("unlock_balance", BALANCE, 64'd400000);

        // Timeout with a partial PIN; the attempt count must not move.
        insert_card();
        enter_pin(wrong_pin(PIN), 0);
        send_digit(PIN[15:12], 1);
        send_digit(PIN[11:8], 1);
        repeat (TMO - 5) @(negedge CLK);
        check_eq("tmo_not_early", 64'(cnt_tmo), 64'(e_tmo));
        for (int i = 0; i < 12 && cnt_tmo == e_tmo; i++) @(negedge CLK);
        e_tmo++;
        check_eq("tmo_pulse", 64'(cnt_tmo), 64'(e_tmo));
        @(negedge CLK);
        check_eq("tmo_state", 64'(state_dbg), 64'(IDLE));
        insert_card();
        enter_pin(wrong_pin(PIN), 0);
        check_eq("tmo_adv_second_wrong", 64'(ADVERTENCIA), 64'd1);
        check_eq("tmo_not_locked", 64'(BLOQUEO), 64'd0);
        enter_pin(PIN, 0);
        cancel_now();
        check_state();

        // Amount strobe while idle is ignored.
        TIPO_TRANS = 1'b0;
        MONTO = 32'd1000;
        MONTO_STB = 1'b1;
        repeat (2) @(negedge CLK);
        MONTO_STB = 1'b0;
        repeat (3) @(negedge CLK);
        check_state();

        // Randomized sessions.
        for (int it = 0; it < 40; it++) begin
            int nw;
            if ($urandom_range(0, 3) == 0) pulse_dia();
            if ($urandom_range(0, 4) == 0) PIN = rand_pin();
            nw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_session(nw, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                        rand_amount(), 0);
            if (m_locked) do_reset();
        end

        check_eq("upd_missing", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
